// File: rtl/lcd_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_frame_sequencer                                                        |
// | HDP panel power sequencing plus frame timing fed from an FWFT FIFO.        |
// | Optional feature: define LCD_INVERT_EN for a per-frame o_invert toggle.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lcd_frame_sequencer #(
  parameter int DATA_WIDTH       = 32,
  parameter int PACKETS_PER_LINE = 40,
  parameter int LINE_BLANK       = 4,
  parameter int LINES            = 1280,
  parameter int BACK_PORCH       = 24,
  parameter int UPDATE_CLOCKS    = 28,
  parameter int RESET_HOLD       = 31,
  parameter int POWER_DELAY      = 1000001,
  parameter int SLEEP_DELAY      = 50000000,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_shutdown,
  output logic                  o_commSetup,
  output logic                  o_commActivate,
  output logic                  o_commShutdown,
  input  logic                  i_commDone,
  input  logic [DATA_WIDTH-1:0] i_fifoData,
  input  logic                  i_fifoEmpty,
  output logic                  o_fifoRead,
  output logic [DATA_WIDTH-1:0] o_lcdData,
  output logic                  o_valid,
  output logic                  o_update,
  output logic                  o_sync,
  output logic                  o_invert,
  output logic                  o_nReset,
  output logic                  o_active,
  output logic                  o_underflow,
  output logic [CNT_WIDTH-1:0]  o_frameCount,
  output logic [3:0]            o_state
);

  typedef enum logic [3:0] {
    START        = 4'd0,
    RESET_WAIT   = 4'd1,
    SETUP        = 4'd2,
    STANDBY      = 4'd3,
    ACTIVATE     = 4'd4,
    NORMAL       = 4'd5,
    SHUTDOWN_CMD = 4'd6,
    SLEEP        = 4'd7,
    OFF          = 4'd8
  } state_t;

  localparam int c_lineLen   = PACKETS_PER_LINE + LINE_BLANK;
  localparam int c_frameLen  = LINES * c_lineLen + BACK_PORCH;
  localparam logic [CNT_WIDTH-1:0] c_one        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_frameLast  = CNT_WIDTH'(c_frameLen - 1);
  localparam logic [CNT_WIDTH-1:0] c_lineLast   = CNT_WIDTH'(c_lineLen - 1);
  localparam logic [CNT_WIDTH-1:0] c_packets    = CNT_WIDTH'(PACKETS_PER_LINE);
  localparam logic [CNT_WIDTH-1:0] c_lines      = CNT_WIDTH'(LINES);
  localparam logic [CNT_WIDTH-1:0] c_update     = CNT_WIDTH'(UPDATE_CLOCKS);
  localparam logic [CNT_WIDTH-1:0] c_resetHold  = CNT_WIDTH'(RESET_HOLD);
  localparam logic [CNT_WIDTH-1:0] c_powerDelay = CNT_WIDTH'(POWER_DELAY);
  localparam logic [CNT_WIDTH-1:0] c_sleepDelay = CNT_WIDTH'(SLEEP_DELAY);

  state_t                 r_state, w_nextState;
  logic [CNT_WIDTH-1:0]   r_delayCnt, r_framePos, r_linePos, r_lineNum, r_frameCount;
  logic                   r_shutdownReq;
  logic                   w_setupReq, w_activateReq, w_shutdownGo;
  logic                   w_inNormal, w_frameEnd, w_frameStart, w_validSlot, w_isDelayState;
  logic [DATA_WIDTH-1:0]  r_lcdData;
  logic                   r_valid, r_update, r_sync, r_nReset, r_active, r_underflow;
  logic                   r_commSetup, r_commActivate, r_commShutdown;

  assign w_inNormal     = (r_state == NORMAL);
  assign w_frameEnd     = w_inNormal && (r_framePos == c_frameLast);
  assign w_frameStart   = w_inNormal && (r_framePos == '0);
  assign w_validSlot    = w_inNormal && (r_lineNum != c_lines) && (r_linePos < c_packets);
  assign w_isDelayState = (r_state == START) || (r_state == RESET_WAIT) ||
                          (r_state == STANDBY) || (r_state == SLEEP);

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= START;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    w_setupReq    = 1'b0;
    w_activateReq = 1'b0;
    w_shutdownGo  = 1'b0;
    case (r_state)
      START:        if (r_delayCnt == c_resetHold) w_nextState = RESET_WAIT;
      RESET_WAIT:   if (r_delayCnt == c_powerDelay) begin
                      w_nextState = SETUP;
                      w_setupReq  = 1'b1;
                    end
      SETUP:        if (i_commDone) w_nextState = STANDBY;
      STANDBY:      if (r_delayCnt == c_powerDelay) begin
                      w_nextState   = ACTIVATE;
                      w_activateReq = 1'b1;
                    end
      ACTIVATE:     if (i_commDone) w_nextState = NORMAL;
      // Shutdown is only honoured on the last porch cycle so frames stay whole
      NORMAL:       if (w_frameEnd && (r_shutdownReq || i_shutdown)) begin
                      w_nextState  = SHUTDOWN_CMD;
                      w_shutdownGo = 1'b1;
                    end
      SHUTDOWN_CMD: if (i_commDone) w_nextState = SLEEP;
      SLEEP:        if (r_delayCnt == c_sleepDelay) w_nextState = OFF;
      OFF:          if (i_enable) w_nextState = START;
      default:      w_nextState = START;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || (w_nextState != r_state) || !w_isDelayState) r_delayCnt <= '0;
    else                                                         r_delayCnt <= r_delayCnt + c_one;
  end

  // Position counters sit at zero outside NORMAL, so entering NORMAL starts at p=0
  always_ff @(posedge i_clock) begin
    if (i_reset || !w_inNormal || w_frameEnd) begin
      r_framePos <= '0;
      r_linePos  <= '0;
      r_lineNum  <= '0;
    end else begin
      r_framePos <= r_framePos + c_one;
      if (r_lineNum != c_lines) begin
        if (r_linePos == c_lineLast) begin
          r_linePos <= '0;
          r_lineNum <= r_lineNum + c_one;
        end else begin
          r_linePos <= r_linePos + c_one;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_frameCount  <= '0;
      r_shutdownReq <= 1'b0;
    end else begin
      if (w_frameEnd) r_frameCount <= r_frameCount + c_one;
      if (!w_inNormal)     r_shutdownReq <= 1'b0;
      else if (i_shutdown) r_shutdownReq <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lcdData      <= '0;
      r_valid        <= 1'b0;
      r_update       <= 1'b0;
      r_sync         <= 1'b0;
      r_nReset       <= 1'b0;
      r_active       <= 1'b0;
      r_underflow    <= 1'b0;
      r_commSetup    <= 1'b0;
      r_commActivate <= 1'b0;
      r_commShutdown <= 1'b0;
    end else begin
      r_lcdData      <= (w_validSlot && !i_fifoEmpty) ? i_fifoData : '0;
      r_valid        <= w_validSlot;
      r_update       <= w_inNormal && (r_framePos < c_update);
      r_sync         <= w_frameStart;
      r_nReset       <= !((w_nextState == START) || (w_nextState == OFF));
      r_active       <= (w_nextState == NORMAL);
      r_commSetup    <= w_setupReq;
      r_commActivate <= w_activateReq;
      r_commShutdown <= w_shutdownGo;
      if (w_frameStart)                    r_underflow <= w_validSlot && i_fifoEmpty;
      else if (w_validSlot && i_fifoEmpty) r_underflow <= 1'b1;
    end
  end

`ifdef LCD_INVERT_EN
  logic r_invert, r_invertPhase;

  // Phase flips at each frame end and is published alongside o_sync
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_invert      <= 1'b0;
      r_invertPhase <= 1'b0;
    end else begin
      if (!w_inNormal)     r_invertPhase <= 1'b0;
      else if (w_frameEnd) r_invertPhase <= ~r_invertPhase;
      if (w_frameStart) r_invert <= r_invertPhase;
    end
  end

  assign o_invert = r_invert;
`else
  assign o_invert = 1'b0;
`endif

  assign o_fifoRead     = w_validSlot && !i_fifoEmpty && !i_reset;
  assign o_lcdData      = r_lcdData;
  assign o_valid        = r_valid;
  assign o_update       = r_update;
  assign o_sync         = r_sync;
  assign o_nReset       = r_nReset;
  assign o_active       = r_active;
  assign o_underflow    = r_underflow;
  assign o_frameCount   = r_frameCount;
  assign o_state        = r_state;
  assign o_commSetup    = r_commSetup;
  assign o_commActivate = r_commActivate;
  assign o_commShutdown = r_commShutdown;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lcd_frame_sequencer                                                     |
// | Directed table-driven bench: power-up, frame geometry, underflow,          |
// | shutdown, mid-frame reset and o_invert (LCD_INVERT_EN aware).              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lcd_frame_sequencer;

  localparam int c_dw     = 16;
  localparam int c_frame  = 23;
  localparam int c_frames = 4;
  localparam int c_nVec   = c_frames * c_frame;

  logic            clk = 1'b0;
  logic            i_reset = 1'b1, i_enable = 1'b0, i_shutdown = 1'b0, i_commDone = 1'b0;
  logic [c_dw-1:0] i_fifoData = '0;
  logic            i_fifoEmpty = 1'b1;
  logic            o_commSetup, o_commActivate, o_commShutdown, o_fifoRead;
  logic [c_dw-1:0] o_lcdData;
  logic            o_valid, o_update, o_sync, o_invert, o_nReset, o_active, o_underflow;
  logic [31:0]     o_frameCount;
  logic [3:0]      o_state;

  int nCompared = 0;
  int nFailed   = 0;

  lcd_frame_sequencer #(
    .DATA_WIDTH(c_dw), .PACKETS_PER_LINE(4), .LINE_BLANK(2), .LINES(3), .BACK_PORCH(5),
    .UPDATE_CLOCKS(3), .RESET_HOLD(3), .POWER_DELAY(10), .SLEEP_DELAY(20), .CNT_WIDTH(32)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_shutdown(i_shutdown),
    .o_commSetup(o_commSetup), .o_commActivate(o_commActivate), .o_commShutdown(o_commShutdown),
    .i_commDone(i_commDone), .i_fifoData(i_fifoData), .i_fifoEmpty(i_fifoEmpty),
    .o_fifoRead(o_fifoRead), .o_lcdData(o_lcdData), .o_valid(o_valid), .o_update(o_update),
    .o_sync(o_sync), .o_invert(o_invert), .o_nReset(o_nReset), .o_active(o_active),
    .o_underflow(o_underflow), .o_frameCount(o_frameCount), .o_state(o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic empty;
    logic expRead;
    logic expValid;
    logic expSync;
    logic expUpdate;
    logic expUnder;
    logic expInvert;
    int   expCount;
  } vec_t;

  vec_t vecs [c_nVec];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Starts in START; acks each comms pulse 5 cycles after it is seen
  task automatic powerUp(output int lowCycles, output int setups, output int acts,
                         output int ackToActive);
    int ackAt, actAck;
    lowCycles = 0; setups = 0; acts = 0; ackAt = -1; actAck = -1000; ackToActive = -1;
    for (int c = 0; c < 200; c++) begin
      if (o_active) begin
        ackToActive = c - actAck;
        break;
      end
      if (!o_nReset) lowCycles++;
      if (o_commSetup) begin setups++; ackAt = c + 5; end
      if (o_commActivate) begin acts++; ackAt = c + 5; actAck = c + 5; end
      i_commDone = (c == ackAt);
      tick();
    end
    i_commDone = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0]     slotMask;
    logic [c_dw-1:0] dataWord, expData;
    int              lowCyc, nSetup, nAct, ackLat, n, pulses;

    // Valid slots: p0-3, p6-9, p12-15; blanks p4-5, p10-11, p16-17; porch p18-22
    slotMask = 23'b00000_00_1111_00_1111_00_1111;
    for (int f = 0; f < c_frames; f++) begin
      for (int p = 0; p < c_frame; p++) begin
        int i;
        i = f * c_frame + p;
        vecs[i].empty     = (f == 1) && (p == 8);
        vecs[i].expValid  = slotMask[p];
        vecs[i].expRead   = slotMask[p] && !vecs[i].empty;
        vecs[i].expSync   = (p == 0);
        vecs[i].expUpdate = (p < 3);
        vecs[i].expUnder  = (f == 1) && (p >= 8);
`ifdef LCD_INVERT_EN
        vecs[i].expInvert = f[0];
`else
        vecs[i].expInvert = 1'b0;
`endif
        vecs[i].expCount  = f + ((p == c_frame - 1) ? 1 : 0);
      end
    end

    repeat (3) tick();
    chk("rst_state",    o_state, 0);
    chk("rst_nReset",   o_nReset, 0);
    chk("rst_valid",    o_valid, 0);
    chk("rst_lcdData",  o_lcdData, 0);
    chk("rst_sync",     o_sync, 0);
    chk("rst_update",   o_update, 0);
    chk("rst_invert",   o_invert, 0);
    chk("rst_comms",    {o_commSetup, o_commActivate, o_commShutdown}, 0);
    chk("rst_under",    o_underflow, 0);
    chk("rst_frameCnt", o_frameCount, 0);
    chk("rst_active",   o_active, 0);
    chk("rst_fifoRead", o_fifoRead, 0);

    i_reset = 1'b0;
    powerUp(lowCyc, nSetup, nAct, ackLat);
    chk("pu_nResetLow", lowCyc, 4);
    chk("pu_setupCnt",  nSetup, 1);
    chk("pu_actCnt",    nAct, 1);
    chk("pu_ackToAct",  ackLat, 1);
    chk("pu_state",     o_state, 5);

    // Frames 0..3 with an underflow in frame 1 and a shutdown request at frame 3 p=7
    dataWord = 16'h0100;
    for (int i = 0; i < c_nVec; i++) begin
      i_fifoEmpty = vecs[i].empty;
      i_fifoData  = dataWord;
      i_shutdown  = (i == 3 * c_frame + 7);
      #1;
      chk("fifoRead", o_fifoRead, vecs[i].expRead);
      expData = vecs[i].expRead ? dataWord : '0;
      if (vecs[i].expRead) dataWord = dataWord + 16'd1;
      tick();
      chk("valid",     o_valid,     vecs[i].expValid);
      chk("lcdData",   o_lcdData,   expData);
      chk("sync",      o_sync,      vecs[i].expSync);
      chk("update",    o_update,    vecs[i].expUpdate);
      chk("underflow", o_underflow, vecs[i].expUnder);
      chk("invert",    o_invert,    vecs[i].expInvert);
      chk("commShutdown", o_commShutdown, (i == c_nVec - 1));
      chk("state",     o_state,     (i == c_nVec - 1) ? 6 : 5);
      if (i != c_nVec - 1) chk("frameCount", o_frameCount, vecs[i].expCount);
    end
    i_shutdown  = 1'b0;
    i_fifoEmpty = 1'b1;

    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_commShutdown) pulses++;
      i_commDone = (c == 5);
      tick();
    end
    i_commDone = 1'b0;
    chk("sd_pulseCnt", pulses, 1);
    chk("sd_sleep",    o_state, 7);
    n = 0;
    while (o_state == 4'd7 && n < 50) begin
      n++;
      tick();
    end
    chk("sd_sleepLen", n, 21);
    chk("sd_off",      o_state, 8);
    chk("sd_nReset",   o_nReset, 0);

    i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    chk("en_start", o_state, 0);
    powerUp(lowCyc, nSetup, nAct, ackLat);
    chk("pu2_nResetLow", lowCyc, 4);
    chk("pu2_ackToAct",  ackLat, 1);

    i_fifoEmpty = 1'b0;
    repeat (10) tick();
    i_reset = 1'b1;
    tick();
    #1;
    chk("mr_state",    o_state, 0);
    chk("mr_valid",    o_valid, 0);
    chk("mr_nReset",   o_nReset, 0);
    chk("mr_frameCnt", o_frameCount, 0);
    chk("mr_fifoRead", o_fifoRead, 0);
    i_reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
`default_nettype wire
